// File: rtl/bp_watch_unit.sv
// bp_watch_unit: memory-mapped breakpoint/watchpoint unit with NUM_BP channels.
// Each channel matches on the issued PC (exec) and/or on data-bus reads/writes
// to an address outside the unit's own register window. It also keeps a
// saturating hit counter. Hits set sticky W1C status bits, capture the
// offending address, and raise a one-cycle hit pulse toward the CPU debug trap.
module bp_watch_unit #(
  parameter int          NUM_BP    = 4,
  parameter logic [31:0] BASE_ADDR = 32'hFFFFF000,
  parameter int          CNT_W     = 16,
  localparam int         IDX_W     = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [15:0]      wdata,
  input  logic             we,
  input  logic             re,
  output logic [15:0]      rdata,
  output logic             ready,
  input  logic [31:0]      pc,
  input  logic             pc_valid,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx,
  output logic             bp_en_any
);

  // Offset of the global block (STATUS, HIT_LO, HIT_HI) from BASE_ADDR.
  localparam logic [31:0] GLOB_OFF = 32'(4 * NUM_BP);

  // Address decode. A channel block is 4 words, so offset[4:2] selects the
  // channel and offset[1:0] the register. The global block is 4-word aligned.
  logic [31:0] offset;
  logic        inWin;
  logic        isGlob;
  logic [2:0]  chSel;
  logic [1:0]  regSel;
  logic        busWr;
  logic        busRd;

  assign offset = addr - BASE_ADDR;
  assign inWin  = (addr >= BASE_ADDR) && (offset <= GLOB_OFF + 32'd2);
  assign isGlob = (offset >= GLOB_OFF);
  assign chSel  = offset[4:2];
  assign regSel = offset[1:0];
  assign busWr  = inWin & we;
  assign busRd  = inWin & re;

  // Per-channel register views gathered for the read mux.
  logic [3:0]       ctrlAll  [NUM_BP];
  logic [15:0]      loAll    [NUM_BP];
  logic [15:0]      hiAll    [NUM_BP];
  logic [CNT_W-1:0] countAll [NUM_BP];
  logic [NUM_BP-1:0] execMatch;
  logic [NUM_BP-1:0] dataMatch;
  logic [NUM_BP-1:0] matchVec;
  logic [NUM_BP-1:0] enVec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BP; gi++) begin : gChan
      logic [3:0]       ctrlReg;
      logic [15:0]      addrLoReg;
      logic [15:0]      addrHiReg;
      logic [CNT_W-1:0] countReg;
      logic [31:0]      bpAddr;
      logic             chWr;

      assign bpAddr = {addrHiReg, addrLoReg};
      assign chWr   = busWr && !isGlob && (chSel == 3'(gi));

      // Matches use the registers as they stand this cycle, so a same-cycle
      // CTRL write never suppresses a match. Accesses to our own window are
      // excluded from data watching.
      assign execMatch[gi] = ctrlReg[0] & ctrlReg[1] & pc_valid & (pc == bpAddr);
      assign dataMatch[gi] = ctrlReg[0] & ~inWin & (addr == bpAddr) &
                             ((ctrlReg[2] & re) | (ctrlReg[3] & we));
      assign matchVec[gi]  = execMatch[gi] | dataMatch[gi];
      assign enVec[gi]     = ctrlReg[0];

      assign ctrlAll[gi]  = ctrlReg;
      assign loAll[gi]    = addrLoReg;
      assign hiAll[gi]    = addrHiReg;
      assign countAll[gi] = countReg;

      // Channel registers; a software COUNT write beats a same-edge increment.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ctrlReg   <= '0;
          addrLoReg <= '0;
          addrHiReg <= '0;
          countReg  <= '0;
        end else begin
          if (chWr && regSel == 2'd0) ctrlReg   <= wdata[3:0];
          if (chWr && regSel == 2'd1) addrLoReg <= wdata;
          if (chWr && regSel == 2'd2) addrHiReg <= wdata;
          if (chWr && regSel == 2'd3)
            countReg <= '0;
          else if (matchVec[gi] && countReg != '1)
            countReg <= countReg + 1'b1;
        end
      end
    end
  endgenerate

  // Global state.
  logic [NUM_BP-1:0] statusReg;
  logic [15:0]       hitLoReg;
  logic [15:0]       hitHiReg;
  logic [15:0]       rdataReg;
  logic              readyReg;
  logic              hitReg;
  logic [IDX_W-1:0]  hitIdxReg;
  logic              bpEnAnyReg;

  logic [IDX_W-1:0]  lowIdx;
  logic [31:0]       capAddr;
  logic [15:0]       readVal;
  logic [NUM_BP-1:0] stClear;

  // Lowest matching channel and the address it reports. If that channel
  // matches on both exec and data in one cycle, the PC is captured.
  always_comb begin
    lowIdx  = '0;
    capAddr = addr;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (matchVec[i]) begin
        lowIdx  = IDX_W'(i);
        capAddr = execMatch[i] ? pc : addr;
      end
    end
  end

  // Read mux over the channel and global registers; unused bits read 0.
  always_comb begin
    readVal = '0;
    if (isGlob) begin
      case (regSel)
        2'd0:    readVal = 16'(statusReg);
        2'd1:    readVal = hitLoReg;
        2'd2:    readVal = hitHiReg;
        default: readVal = '0;
      endcase
    end else begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (chSel == 3'(i)) begin
          case (regSel)
            2'd0:    readVal = {12'd0, ctrlAll[i]};
            2'd1:    readVal = loAll[i];
            2'd2:    readVal = hiAll[i];
            default: readVal = 16'(countAll[i]);
          endcase
        end
      end
    end
  end

  assign stClear = (busWr && isGlob && regSel == 2'd0) ? wdata[NUM_BP-1:0] : '0;

  // Status (W1C, new hits win), hit capture, bus handshake and read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      statusReg  <= '0;
      hitLoReg   <= '0;
      hitHiReg   <= '0;
      rdataReg   <= '0;
      readyReg   <= 1'b0;
      hitReg     <= 1'b0;
      hitIdxReg  <= '0;
      bpEnAnyReg <= 1'b0;
    end else begin
      statusReg  <= (statusReg & ~stClear) | matchVec;
      hitReg     <= |matchVec;
      bpEnAnyReg <= |enVec;
      readyReg   <= busRd | busWr;
      if (|matchVec) begin
        hitIdxReg <= lowIdx;
        hitLoReg  <= capAddr[15:0];
        hitHiReg  <= capAddr[31:16];
      end
      if (busRd && !we) rdataReg <= readVal;
    end
  end

  assign rdata     = rdataReg;
  assign ready     = readyReg;
  assign hit       = hitReg;
  assign hit_idx   = hitIdxReg;
  assign bp_en_any = bpEnAnyReg;

endmodule

// File: tb/tb_bp_watch_unit.sv
// Testbench for bp_watch_unit: register table, directed corner sequences and
// a randomized phase, all checked against a behavioural model of the unit.
module tb_bp_watch_unit;

  localparam int          NB    = 4;
  localparam logic [31:0] BASE  = 32'hFFFFF000;
  localparam int          CNTW  = 4;
  localparam int          CMAX  = 15;
  localparam logic [31:0] G     = BASE + 32'(4 * NB);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [15:0] rdata;
  logic        ready;
  logic [31:0] pc = '0;
  logic        pc_valid = 1'b0;
  logic        hit;
  logic [1:0]  hit_idx;
  logic        bp_en_any;

  bp_watch_unit #(.NUM_BP(NB), .BASE_ADDR(BASE), .CNT_W(CNTW)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .ready(ready), .pc(pc), .pc_valid(pc_valid),
    .hit(hit), .hit_idx(hit_idx), .bp_en_any(bp_en_any)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] chAddr(input int k, input int r);
    return BASE + 32'(4 * k + r);
  endfunction

  // ---------------- behavioural model ----------------
  logic [3:0]  mCtrl [NB];
  logic [15:0] mLo [NB];
  logic [15:0] mHi [NB];
  int          mCnt [NB];
  logic [3:0]  mStat;
  logic [15:0] mHLo, mHHi;
  logic [15:0] eRdata;
  logic        eReady, eHit, eEnAny;
  int          eIdx;

  task automatic modelReset();
    for (int k = 0; k < NB; k++) begin
      mCtrl[k] = '0; mLo[k] = '0; mHi[k] = '0; mCnt[k] = 0;
    end
    mStat = '0; mHLo = '0; mHHi = '0;
    eRdata = '0; eReady = 0; eHit = 0; eEnAny = 0; eIdx = 0;
  endtask

  function automatic logic [15:0] modelRead(input int off);
    int k;
    k = off / 4;
    if (off >= 4 * NB) begin
      case (off - 4 * NB)
        0: return {12'd0, mStat};
        1: return mHLo;
        default: return mHHi;
      endcase
    end
    case (off % 4)
      0: return {12'd0, mCtrl[k]};
      1: return mLo[k];
      2: return mHi[k];
      default: return 16'(mCnt[k]);
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelStep();
    bit   inWin;
    int   off, low, k;
    bit   m [NB];
    bit   mx [NB];
    logic [31:0] full, cap;
    inWin = (addr >= BASE) && ((addr - BASE) <= 32'(4 * NB + 2));
    off = inWin ? int'(addr - BASE) : 0;
    low = -1;
    eEnAny = 0;
    for (int i = 0; i < NB; i++) begin
      full = {mHi[i], mLo[i]};
      mx[i] = mCtrl[i][0] && mCtrl[i][1] && pc_valid && (pc == full);
      m[i] = mx[i] || (mCtrl[i][0] && !inWin && (addr == full) &&
                       ((mCtrl[i][2] && re) || (mCtrl[i][3] && we)));
      if (m[i] && low < 0) low = i;
      if (mCtrl[i][0]) eEnAny = 1;
    end
    eReady = inWin && (re || we);
    if (inWin && re && !we) eRdata = modelRead(off);
    eHit = (low >= 0);
    for (int i = 0; i < NB; i++)
      if (m[i] && mCnt[i] < CMAX) mCnt[i]++;
    if (inWin && we && off == 4 * NB) mStat = mStat & ~wdata[3:0];
    for (int i = 0; i < NB; i++)
      if (m[i]) mStat[i] = 1'b1;
    if (eHit) begin
      eIdx = low;
      cap = mx[low] ? pc : addr;
      mHLo = cap[15:0];
      mHHi = cap[31:16];
    end
    if (inWin && we && off < 4 * NB) begin
      k = off / 4;
      case (off % 4)
        0: mCtrl[k] = wdata[3:0];
        1: mLo[k] = wdata;
        2: mHi[k] = wdata;
        default: mCnt[k] = 0;
      endcase
    end
  endtask

  // One clock: inputs applied at the falling edge, outputs compared at the next one.
  task automatic cycle();
    modelStep();
    @(posedge clk);
    @(negedge clk);
    chk("ready", ready, eReady);
    chk("hit", hit, eHit);
    if (eHit) chk("hit_idx", hit_idx, 32'(eIdx));
    chk("rdata", rdata, eRdata);
    chk("bp_en_any", bp_en_any, eEnAny);
  endtask

  task automatic idle();
    addr = '0; wdata = '0; we = 0; re = 0; pc = '0; pc_valid = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [15:0] d);
    idle(); addr = a; wdata = d; we = 1;
    cycle();
    $display("wr addr=%h data=%h ready=%0b hit=%0b", a, d, ready, hit);
    idle();
  endtask

  task automatic rd(input logic [31:0] a, input logic [15:0] exp, input string name);
    idle(); addr = a; re = 1;
    cycle();
    $display("rd addr=%h data=%h ready=%0b", a, rdata, ready);
    chk(name, rdata, exp);
    chk({name, "_ready"}, ready, 1);
    idle();
  endtask

  task automatic execCycles(input int n);
    idle(); pc = 32'h00001234; pc_valid = 1;
    repeat (n) cycle();
    idle();
  endtask

  typedef struct {
    bit          we;
    bit          re;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [15:0] expRdata;
    bit          expReady;
  } vec_t;

  vec_t        vecs [$];
  logic [31:0] pool [4];

  initial begin
    int op, k, r, j;
    logic [31:0] tmp;

    vecs.push_back('{1, 0, chAddr(1, 0), 16'h0003, 16'h0000, 1});
    vecs.push_back('{1, 0, chAddr(1, 1), 16'h1234, 16'h0000, 1});
    vecs.push_back('{1, 0, chAddr(1, 2), 16'h0000, 16'h0000, 1});
    vecs.push_back('{0, 1, chAddr(1, 0), 16'h0000, 16'h0003, 1});
    vecs.push_back('{0, 1, chAddr(1, 1), 16'h0000, 16'h1234, 1});
    vecs.push_back('{0, 1, chAddr(1, 2), 16'h0000, 16'h0000, 1});
    vecs.push_back('{1, 0, chAddr(2, 0), 16'hFFFF, 16'h0000, 1});
    vecs.push_back('{0, 1, chAddr(2, 0), 16'h0000, 16'h000F, 1});
    vecs.push_back('{1, 0, chAddr(2, 0), 16'h0000, 16'h000F, 1});
    vecs.push_back('{0, 1, chAddr(2, 0), 16'h0000, 16'h0000, 1});
    vecs.push_back('{1, 1, chAddr(3, 1), 16'hABCD, 16'h0000, 1});
    vecs.push_back('{0, 1, chAddr(3, 1), 16'h0000, 16'hABCD, 1});
    vecs.push_back('{1, 0, chAddr(3, 1), 16'h0000, 16'hABCD, 1});
    vecs.push_back('{0, 1, BASE - 32'd1, 16'h0000, 16'hABCD, 0});
    vecs.push_back('{0, 1, G + 32'd3,    16'h0000, 16'hABCD, 0});
    vecs.push_back('{1, 0, G + 32'd1,    16'hFFFF, 16'hABCD, 1});
    vecs.push_back('{0, 1, G + 32'd1,    16'h0000, 16'h0000, 1});

    pool[0] = 32'h00001234; pool[1] = 32'hD0000010;
    pool[2] = 32'h00000040; pool[3] = 32'hFFFFF004;

    // Reset and check the idle outputs.
    modelReset();
    #1 rst = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_rdata", rdata, 0);
    chk("rst_ready", ready, 0);
    chk("rst_hit", hit, 0);
    chk("rst_hit_idx", hit_idx, 0);
    chk("rst_en_any", bp_en_any, 0);
    rst = 1;
    @(negedge clk);

    rd(chAddr(0, 0), 16'h0000, "ctrl0_reset");
    cycle();
    chk("ready_one_cycle", ready, 0);

    // Register table.
    foreach (vecs[i]) begin
      idle();
      addr = vecs[i].addr; wdata = vecs[i].wdata; we = vecs[i].we; re = vecs[i].re;
      cycle();
      $display("vec %0d addr=%h we=%0b re=%0b rdata=%h ready=%0b",
               i, addr, we, re, rdata, ready);
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].expRdata);
      chk($sformatf("vec%0d_ready", i), ready, vecs[i].expReady);
    end
    idle();

    // Exec match on channel 1 for three consecutive cycles.
    idle(); pc = 32'h00001234; pc_valid = 1;
    for (int n = 0; n < 3; n++) begin
      cycle();
      chk("exec_hit", hit, 1);
      chk("exec_idx", hit_idx, 1);
    end
    idle();
    cycle();
    chk("exec_hit_end", hit, 0);
    chk("en_any_on", bp_en_any, 1);
    rd(chAddr(1, 3), 16'h0003, "exec_count");
    rd(G, 16'h0002, "exec_status");
    rd(G + 32'd1, 16'h1234, "exec_hit_lo");
    wr(G, 16'h0002);
    rd(G, 16'h0000, "w1c_clear");
    wr(chAddr(1, 0), 16'h0000);

    // Channels 0 and 2 write-watch the same address.
    for (int c = 0; c <= 2; c += 2) begin
      wr(chAddr(c, 1), 16'h0010);
      wr(chAddr(c, 2), 16'hD000);
      wr(chAddr(c, 0), 16'h0009);
    end
    wr(32'hD0000010, 16'h5555);
    chk("data_hit", hit, 1);
    chk("data_idx", hit_idx, 0);
    chk("data_no_ready", ready, 0);
    cycle();
    chk("data_single_pulse", hit, 0);
    rd(G, 16'h0005, "data_status");
    rd(G + 32'd1, 16'h0010, "data_hit_lo");
    rd(G + 32'd2, 16'hD000, "data_hit_hi");
    rd(chAddr(2, 3), 16'h0001, "data_count2");

    // A watch on an address inside the window never fires.
    wr(chAddr(3, 1), 16'hF00C);
    wr(chAddr(3, 2), 16'hFFFF);
    wr(chAddr(3, 0), 16'h000D);
    rd(chAddr(3, 0), 16'h000D, "win_watch_rd");
    chk("win_watch_nohit", hit, 0);
    for (int c = 0; c < NB; c++) if (c != 1) wr(chAddr(c, 0), 16'h0000);
    wr(G, 16'h000F);

    // Counter saturation and same-edge conflicts on channel 1.
    wr(chAddr(1, 0), 16'h0003);
    wr(chAddr(1, 3), 16'h0000);
    execCycles(20);
    rd(chAddr(1, 3), 16'h000F, "count_sat");
    idle(); pc = 32'h00001234; pc_valid = 1; addr = chAddr(1, 3); we = 1;
    cycle();
    chk("count_clr_hit", hit, 1);
    idle();
    rd(chAddr(1, 3), 16'h0000, "count_clear_wins");
    idle(); pc = 32'h00001234; pc_valid = 1; addr = G; wdata = 16'h0002; we = 1;
    cycle();
    idle();
    rd(G, 16'h0002, "status_set_wins");
    wr(G, 16'h0002);
    rd(G, 16'h0000, "status_w1c");
    idle(); pc = 32'h00001234; pc_valid = 1; addr = chAddr(1, 0); wdata = 16'h0000; we = 1;
    cycle();
    chk("disable_same_cycle_hit", hit, 1);
    addr = '0; we = 0;
    cycle();
    chk("disabled_no_hit", hit, 0);
    idle();
    cycle();
    chk("en_any_off", bp_en_any, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      idle();
      pc = pool[$urandom_range(0, 3)];
      pc_valid = 1'($urandom_range(0, 1));
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: begin
          k = $urandom_range(0, NB - 1);
          r = $urandom_range(0, 3);
          j = $urandom_range(0, 3);
          tmp = pool[j];
          addr = chAddr(k, r); we = 1;
          wdata = (r == 1) ? tmp[15:0] : (r == 2) ? tmp[31:16] : 16'($urandom);
        end
        3: begin addr = G; we = 1; wdata = 16'($urandom_range(0, 15)); end
        4, 5: begin addr = BASE + 32'($urandom_range(0, 4 * NB + 3)); re = 1; end
        6: begin
          addr = pool[$urandom_range(0, 3)];
          we = 1'($urandom_range(0, 1));
          re = 1'($urandom_range(0, 1));
          wdata = 16'($urandom);
        end
        default: ;
      endcase
      cycle();
    end
    idle();

    // Reset asserted while a read result is on the bus.
    wr(chAddr(1, 0), 16'h0003);
    idle(); addr = chAddr(1, 0); re = 1;
    @(posedge clk);
    #2;
    chk("pre_rst_ready", ready, 1);
    chk("pre_rst_rdata", rdata, 16'h0003);
    rst = 0;
    #1;
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_hit", hit, 0);
    modelReset();
    idle();
    @(negedge clk);
    rst = 1;
    cycle();
    chk("post_rst_ready", ready, 0);
    for (int c = 0; c < NB; c++) rd(chAddr(c, 0), 16'h0000, $sformatf("post_rst_ctrl%0d", c));
    chk("post_rst_en_any", bp_en_any, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
